// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: sequences the 3-product 16x16 multiplier cell into Nios II MUL/MULX* results.
// Low word takes one cell pass; high words take a second pass for a_hi*b_hi plus signed correction.
module nios2_mul_seq #(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);
    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIX, DONE} state_t;
    localparam logic [1:0] CNT_INIT = 2'(CELL_LAT - 1);

    state_t      state_q;
    logic [31:0] a_q, b_q, ll_q, hh_q, rsp_q;
    logic [32:0] cross_q;
    logic [1:0]  op_q, cnt_q;
    logic [32:0] cross_d;
    logic [31:0] mul_d, hi_d;
    logic [63:0] u;
    logic        lo_pass, hi_pass;

    always_comb begin
        cross_d = {1'b0, cell_p2} + {1'b0, cell_p3};
        mul_d   = cell_p1 + {cross_d[15:0], 16'h0};
        u       = {hh_q, 32'h0} + {15'h0, cross_q, 16'h0} + {32'h0, ll_q};
        hi_d    = u[63:32] - ((op_q[1] && a_q[31]) ? b_q : 32'h0)
                           - ((op_q == 2'b11 && b_q[31]) ? a_q : 32'h0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            ll_q    <= '0;
            cross_q <= '0;
            hh_q    <= '0;
            rsp_q   <= '0;
        end else if (flush && state_q != IDLE) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    a_q     <= req_a;
                    b_q     <= req_b;
                    op_q    <= req_op;
                    state_q <= ISSUE1;
                end
                ISSUE1: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT1;
                end
                WAIT1: if (cnt_q == 2'd0) begin
                    ll_q    <= cell_p1;
                    cross_q <= cross_d;
                    rsp_q   <= mul_d;
                    state_q <= (op_q == 2'b00) ? DONE : ISSUE2;
                end else cnt_q <= cnt_q - 2'd1;
                ISSUE2: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT2;
                end
                WAIT2: if (cnt_q == 2'd0) begin
                    hh_q    <= cell_p1;
                    state_q <= FIX;
                end else cnt_q <= cnt_q - 2'd1;
                FIX: begin
                    rsp_q   <= hi_d;
                    state_q <= DONE;
                end
                DONE: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Second pass steers the high halves into the low lanes so p1 yields a_hi*b_hi.
    assign lo_pass   = state_q == ISSUE1 || state_q == WAIT1;
    assign hi_pass   = state_q == ISSUE2 || state_q == WAIT2;
    assign req_ready = state_q == IDLE;
    assign cell_en   = lo_pass || hi_pass;
    assign cell_src1 = lo_pass ? a_q : hi_pass ? {16'h0, a_q[31:16]} : 32'h0;
    assign cell_src2 = lo_pass ? b_q : hi_pass ? {16'h0, b_q[31:16]} : 32'h0;
    assign rsp_valid = state_q == DONE;
    assign rsp_data  = (state_q == DONE) ? rsp_q : 32'h0;
endmodule

// File: tb/tb_nios2_mul_seq.sv
// tb_nios2_mul_seq: checks the multiply sequencer with CELL_LAT=1 and CELL_LAT=3 against a 64-bit product model.
module tb_nios2_mul_seq;
    logic clk = 0, reset_n = 0;
    always #5 clk = ~clk;

    logic        req_valid = 0, rsp_ready = 1, flush = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic [1:0]  req_op = 0;

    logic        r1_ready, r1_valid, en1;
    logic [31:0] r1_data, s1a, s1b, p1_1, p2_1, p3_1;
    logic        r3_ready, r3_valid, en3;
    logic [31:0] r3_data, s3a, s3b, p1_3, p2_3, p3_3;

    nios2_mul_seq #(.CELL_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(r1_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .flush(flush),
        .rsp_valid(r1_valid), .rsp_ready(rsp_ready), .rsp_data(r1_data),
        .cell_src1(s1a), .cell_src2(s1b), .cell_en(en1),
        .cell_p1(p1_1), .cell_p2(p2_1), .cell_p3(p3_1));

    nios2_mul_seq #(.CELL_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(r3_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .flush(flush),
        .rsp_valid(r3_valid), .rsp_ready(rsp_ready), .rsp_data(r3_data),
        .cell_src1(s3a), .cell_src2(s3b), .cell_en(en3),
        .cell_p1(p1_3), .cell_p2(p2_3), .cell_p3(p3_3));

    function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
        return {16'h0, x} * {16'h0, y};
    endfunction

    // Behavioural multiplier cells: LAT register stages, advancing only while enabled.
    logic [31:0] c1 = 0, c2 = 0, c3 = 0;
    always @(posedge clk) if (en1) begin
        c1 <= mul16(s1a[15:0], s1b[15:0]);
        c2 <= mul16(s1a[15:0], s1b[31:16]);
        c3 <= mul16(s1a[31:16], s1b[15:0]);
    end
    assign p1_1 = c1;
    assign p2_1 = c2;
    assign p3_1 = c3;

    logic [31:0] q1[3], q2[3], q3[3];
    initial for (int i = 0; i < 3; i++) begin q1[i] = 0; q2[i] = 0; q3[i] = 0; end
    always @(posedge clk) if (en3) begin
        q1[0] <= mul16(s3a[15:0], s3b[15:0]);
        q2[0] <= mul16(s3a[15:0], s3b[31:16]);
        q3[0] <= mul16(s3a[31:16], s3b[15:0]);
        for (int i = 1; i < 3; i++) begin q1[i] <= q1[i-1]; q2[i] <= q2[i-1]; q3[i] <= q3[i-1]; end
    end
    assign p1_3 = q1[2];
    assign p2_3 = q2[2];
    assign p3_3 = q3[2];

    int errs = 0, checks = 0, en_cnt = 0;
    always @(negedge clk) if (en1) en_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = op[1] ? {{32{a[31]}}, a} : {32'h0, a};
        be = (op == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ae * be;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issues one request, returns edges from accept to rsp_valid; completes the handshake if rsp_ready.
    task automatic run(input bit w3, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output int lat);
        @(negedge clk);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0; req_a = $urandom; req_b = $urandom;
        lat = 0; d = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (w3 ? r3_valid : r1_valid) begin lat = n; d = w3 ? r3_data : r1_data; break; end
        end
        if (lat == 0) begin
            checks++; errs++;
            $display("FAIL timeout: rsp_valid never rose, required within 40 edges");
        end
        if (rsp_ready) begin @(posedge clk); #1; end
    endtask

    typedef struct {logic [1:0] op; logic [31:0] a, b, exp; int lat, en;} vec_t;
    vec_t tbl[8];

    initial begin
        logic [31:0] d, e;
        logic [1:0]  op;
        int lat;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, e, a, b;
        logic [1:0]  op;
        int lat;
        bit seen;
        tbl[0] = '{2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 2, 2};
        tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 4};
        tbl[2] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5, 4};
        tbl[3] = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 5, 4};
        tbl[4] = '{2'b11, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 5, 4};
        tbl[5] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 4};
        tbl[6] = '{2'b10, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 5, 4};
        tbl[7] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2, 2};

        repeat (2) @(negedge clk);
        chk("reset rsp_valid", {31'h0, r1_valid}, 0);
        chk("reset cell_en", {31'h0, en1}, 0);
        chk("reset rsp_data", r1_data, 0);
        chk("reset cell_src1", s1a, 0);
        chk("reset cell_src2", s1b, 0);
        reset_n = 1;
        #1 chk("idle req_ready", {31'h0, r1_ready}, 1);

        for (int i = 0; i < 8; i++) begin
            en_cnt = 0;
            run(0, tbl[i].op, tbl[i].a, tbl[i].b, d, lat);
            chk($sformatf("vec%0d data", i), d, tbl[i].exp);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d cell_en cycles", i), en_cnt, tbl[i].en);
            chk($sformatf("vec%0d post rsp_valid", i), {31'h0, r1_valid}, 0);
            chk($sformatf("vec%0d post req_ready", i), {31'h0, r1_ready}, 1);
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            if (i % 4 == 0) a[31] = 1;
            if (i % 3 == 0) b[31] = 1;
            run(0, op, a, b, d, lat);
            chk($sformatf("rand%0d op%0d %h*%h", i, op, a, b), d, model(op, a, b));
            chk($sformatf("rand%0d latency", i), lat, (op == 2'b00) ? 2 : 5);
        end

        // Second pass lane steering for MULXUU.
        @(negedge clk);
        req_valid = 1; req_op = 2'b01; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF;
        @(posedge clk); #1 req_valid = 0;
        chk("issue1 src1", s1a, 32'hFFFFFFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("issue2 src1", s1a, 32'h0000FFFF);
        chk("issue2 src2", s1b, 32'h0000FFFF);
        chk("issue2 cell_en", {31'h0, en1}, 1);
        @(posedge clk); #1 chk("wait2 src1", s1a, 32'h0000FFFF);
        @(posedge clk); #1;
        chk("fix cell_en", {31'h0, en1}, 0);
        chk("fix src1", s1a, 0);
        @(posedge clk); #1;
        chk("done rsp_valid", {31'h0, r1_valid}, 1);
        chk("done rsp_data", r1_data, 32'hFFFFFFFE);
        @(posedge clk); #1;

        // Backpressure: result held, busy requests ignored.
        rsp_ready = 0;
        run(0, 2'b00, 32'h12345678, 32'h9ABCDEF0, d, lat);
        e = model(2'b00, 32'h12345678, 32'h9ABCDEF0);
        chk("bp data", d, e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin req_valid = 1; req_op = 2'b01; req_a = 32'h5; req_b = 32'h7; end
            @(posedge clk); #1 req_valid = 0;
            chk($sformatf("bp%0d rsp_valid", k), {31'h0, r1_valid}, 1);
            chk($sformatf("bp%0d rsp_data", k), r1_data, e);
            chk($sformatf("bp%0d req_ready", k), {31'h0, r1_ready}, 0);
        end
        @(negedge clk) rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp release rsp_valid", {31'h0, r1_valid}, 0);
        chk("bp release req_ready", {31'h0, r1_ready}, 1);
        @(posedge clk); #1 chk("bp pulse ignored", {31'h0, r1_ready}, 1);

        // Flush in WAIT2 abandons the operation.
        @(negedge clk);
        req_valid = 1; req_op = 2'b11; req_a = 32'h80000000; req_b = 32'h3;
        @(posedge clk); #1 req_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("wait2 cell_en", {31'h0, en1}, 1);
        @(negedge clk) flush = 1;
        @(posedge clk); #1 flush = 0;
        chk("flush rsp_valid", {31'h0, r1_valid}, 0);
        chk("flush cell_en", {31'h0, en1}, 0);
        chk("flush req_ready", {31'h0, r1_ready}, 1);
        seen = 0;
        repeat (8) begin @(posedge clk); #1 if (r1_valid) seen = 1; end
        chk("flush no response", {31'h0, seen}, 0);

        // Flush while idle does not block a simultaneous request.
        @(negedge clk);
        flush = 1; req_valid = 1; req_op = 2'b00; req_a = 32'h0000FFFF; req_b = 32'h00010001;
        @(posedge clk); #1 begin flush = 0; req_valid = 0; end
        chk("idle flush accepted", {31'h0, r1_ready}, 0);
        repeat (2) @(posedge clk);
        #1 chk("idle flush data", r1_data, model(2'b00, 32'h0000FFFF, 32'h00010001));
        @(posedge clk); #1;

        // Reset in WAIT1.
        @(negedge clk);
        req_valid = 1; req_op = 2'b01; req_a = 32'hDEADBEEF; req_b = 32'hCAFEF00D;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 chk("wait1 cell_en", {31'h0, en1}, 1);
        reset_n = 0;
        #1;
        chk("async reset cell_en", {31'h0, en1}, 0);
        chk("async reset src1", s1a, 0);
        chk("async reset src2", s1b, 0);
        chk("async reset rsp_valid", {31'h0, r1_valid}, 0);
        chk("async reset rsp_data", r1_data, 0);
        @(negedge clk) reset_n = 1;
        seen = 0;
        repeat (8) begin @(posedge clk); #1 if (r1_valid || r3_valid) seen = 1; end
        chk("reset no response", {31'h0, seen}, 0);

        // CELL_LAT=3 instance.
        run(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, d, lat);
        chk("lat3 mulxuu data", d, 32'hFFFFFFFE);
        chk("lat3 mulxuu latency", lat, 9);
        run(1, 2'b00, 32'h00010003, 32'h00020005, d, lat);
        chk("lat3 mul data", d, 32'h000B000F);
        chk("lat3 mul latency", lat, 4);
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            run(1, op, a, b, d, lat);
            chk($sformatf("lat3 rand%0d op%0d %h*%h", i, op, a, b), d, model(op, a, b));
            chk($sformatf("lat3 rand%0d latency", i), lat, (op == 2'b00) ? 4 : 9);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/nios2_mul_seq.md
Name: nios2_mul_seq

Overview:
- Sequencer that drives the three-product 16x16 multiplier cell (p1 = src1[15:0]*src2[15:0], p2 = src1[15:0]*src2[31:16], p3 = src1[31:16]*src2[15:0], unsigned, registered) to produce full Nios II multiply results.
- Results produced: MUL (low 32 bits), MULXUU, MULXSU and MULXSS (high 32 bits).
- Runs one pass for the low word. Runs two passes for high words: the second pass obtains a_hi*b_hi by steering the high halves into the low lanes. Signed correction is then applied.
- Sits between the execute-stage request path and the mult cell. It is the only master of the cell.

Parameters:
- CELL_LAT, 1: number of clock edges, with cell enable high, from operands applied to products valid. Legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_a  in  32  operand rA.
- req_b  in  32  operand rB.
- req_op  in  2  00 MUL, 01 MULXUU, 10 MULXSU (rA signed, rB unsigned), 11 MULXSS.
- flush  in  1  synchronous abort of the in-flight operation.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  result consumed.
- rsp_data  out  32  result word.
- cell_src1  out  32  to cell src1.
- cell_src2  out  32  to cell src2.
- cell_en  out  1  to cell register enable.
- cell_p1  in  32  from cell.
- cell_p2  in  32  from cell.
- cell_p3  in  32  from cell.

Behaviour:
- Reset: one clock; reset is asynchronous, active-low on reset_n. All state goes to IDLE. All outputs are 0, except req_ready, which is 1 once in IDLE. Internal regs are cleared.
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIX, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch a, b, op; go to ISSUE1.
  - req_ready is 0 in every other state.
- ISSUE1:
  - cell_src1 = a, cell_src2 = b, cell_en = 1.
  - Next state is WAIT1.
  - A 2-bit counter is loaded with CELL_LAT-1.
- WAIT1:
  - Operands and cell_en are held.
  - The counter decrements each edge.
  - On the edge where the counter is 0: capture ll = p1 and cross = p2 + p3 (33 bits, carry kept).
  - If op = MUL: rsp_data = ll + (cross[15:0] << 16), mod 2^32; go to DONE.
  - Otherwise go to ISSUE2.
- ISSUE2 / WAIT2:
  - cell_src1 = {16'h0, a[31:16]}, cell_src2 = {16'h0, b[31:16]}, cell_en = 1.
  - Same counting as WAIT1. At the end, capture hh = p1 and go to FIX.
- FIX:
  - Compute U = (hh << 32) + (cross << 16) + ll in 64 bits.
  - hi = U[63:32].
  - MULXSU: hi -= (a[31] ? b : 0).
  - MULXSS: hi -= (a[31] ? b : 0) + (b[31] ? a : 0).
  - All of this is mod 2^32. rsp_data = hi; go to DONE.
- cell_en is 0 in IDLE, FIX and DONE. cell_src1/cell_src2 are 0 in those states.
- DONE:
  - rsp_valid = 1. rsp_data is held stable until rsp_valid && rsp_ready.
  - Then go to IDLE. rsp_valid drops on that edge.
- Latency, from accept edge to rsp_valid high: MUL = 1+CELL_LAT edges; high ops = 3+2*CELL_LAT edges. With CELL_LAT=1 that is 2 and 5.
- Throughput: a new request can be accepted one cycle after the response handshake.
- flush: in any non-IDLE state, go to IDLE at the next edge.
  - rsp_valid and cell_en drop, and no response is produced.
  - flush has priority over a simultaneous rsp handshake; the transfer still counts as complete on the consumer side.
  - flush in IDLE has no effect, and a req_valid in that same cycle is still accepted.
- reset_n asserted mid-operation: immediate return to reset values; no response.
- req_valid while busy is ignored; inputs need not be held.

Test Plan:
- MUL, a=0x00010003, b=0x00020005, rsp_ready=1, CELL_LAT=1 -> rsp_data 0x000B000F, rsp_valid 2 edges after accept, cell_en high for exactly 2 cycles.
- MULXUU, a=b=0xFFFFFFFF -> rsp_data 0xFFFFFFFE, 5 edges after accept. Second-pass cell_src1 = cell_src2 = 0x0000FFFF.
- MULXSS: -1*-1 -> 0x00000000; 0x80000000*0x80000000 -> 0x40000000; 0x80000000*0x00000001 -> 0xFFFFFFFF.
- MULXSU, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. With a=0x00000002 and the same b -> 0x00000001.
- Backpressure: rsp_ready low for 3 cycles -> rsp_valid/rsp_data stable, req_ready 0, and a req_valid pulse meanwhile is not accepted. After the handshake, req_ready is 1 on the next cycle.
- flush asserted in WAIT2 -> IDLE next edge, no rsp_valid, cell_en 0. Separately, reset_n low in WAIT1 -> all outputs 0 immediately. Rerun the MULXUU case with CELL_LAT=3 -> same result at 9 edges.
